// File: rtl/nearest_value_finder_pkg.sv
// Shared types and constants for the nearest/farthest value search.
package nvf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } nvf_state_t;

    localparam int MODE_NEAREST  = 0;
    localparam int MODE_FARTHEST = 1;

    // Index width for a given candidate count; never narrower than one bit.
    function automatic int idx_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/nearest_value_finder_if.sv
// Start/candidate/result bus of the value finder.
interface nearest_value_finder_if
    import nvf_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int COUNT = 4
);
    localparam int IW = idx_width(COUNT);

    logic             start;
    logic [WIDTH-1:0] ref_in;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [IW-1:0]    out_index;
    logic [WIDTH-1:0] out_dist;
    logic             busy;

    modport master (
        output start, ref_in, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_dist, busy
    );

    modport slave (
        input  start, ref_in, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_index, out_dist, busy
    );

endinterface

// File: rtl/nearest_value_finder_abs_distance.sv
// Combinational |a - b|: subtract the smaller operand from the larger so it never wraps.
module abs_distance #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] dist_o
);

    assign dist_o = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);

endmodule

// File: rtl/nearest_value_finder.sv
// Streaming nearest/farthest search: latch a reference, scan COUNT candidates,
// hold the winner (value, arrival index, distance) until the consumer takes it.
module nearest_value_finder
    import nvf_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int COUNT = 4,
    parameter int MODE  = MODE_NEAREST
) (
    input logic                  clk,
    input logic                  rst,
    nearest_value_finder_if.slave bus
);

    localparam int            IW   = idx_width(COUNT);
    localparam logic [IW-1:0] LAST = IW'(COUNT - 1);

    nvf_state_t       state_q, state_d;
    logic [WIDTH-1:0] ref_q;
    logic [WIDTH-1:0] best_data_q;
    logic [IW-1:0]    best_idx_q;
    logic [WIDTH-1:0] best_dist_q;
    logic [IW-1:0]    cnt_q;

    logic             beat;
    logic             last_beat;
    logic             better;
    logic [WIDTH-1:0] cand_dist;

    abs_distance #(.WIDTH(WIDTH)) u_abs_distance (
        .a_i    (ref_q),
        .b_i    (bus.in_data),
        .dist_o (cand_dist)
    );

    assign beat      = (state_q == SCAN) && bus.in_valid;
    assign last_beat = beat && (cnt_q == LAST);
    // Strict compare keeps the earliest candidate on a tie.
    assign better    = (MODE == MODE_FARTHEST) ? (cand_dist > best_dist_q)
                                               : (cand_dist < best_dist_q);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = SCAN;
            end
            SCAN: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b1;
                if (last_beat) state_d = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reference capture, beat counter and running best.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_q       <= '0;
            cnt_q       <= '0;
            best_data_q <= '0;
            best_idx_q  <= '0;
            best_dist_q <= '0;
        end else if (state_q == IDLE && bus.start) begin
            ref_q <= bus.ref_in;
            cnt_q <= '0;
        end else if (beat) begin
            if (cnt_q == '0 || better) begin
                best_data_q <= bus.in_data;
                best_idx_q  <= cnt_q;
                best_dist_q <= cand_dist;
            end
            if (!last_beat) cnt_q <= cnt_q + IW'(1);
        end
    end

    assign bus.out_data  = best_data_q;
    assign bus.out_index = best_idx_q;
    assign bus.out_dist  = best_dist_q;

endmodule

// File: tb/tb_nearest_value_finder.sv
// Drives a nearest (MODE 0) and a farthest (MODE 1) finder in lockstep with
// the same stimulus and compares both against a plain arithmetic reference.
module tb_nearest_value_finder;
    import nvf_pkg::*;

    localparam int WIDTH = 8;
    localparam int COUNT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             start     = 1'b0;
    logic [WIDTH-1:0] ref_in    = '0;
    logic             in_valid  = 1'b0;
    logic [WIDTH-1:0] in_data   = '0;
    logic             out_ready = 1'b0;

    nearest_value_finder_if #(.WIDTH(WIDTH), .COUNT(COUNT)) bus0 ();
    nearest_value_finder_if #(.WIDTH(WIDTH), .COUNT(COUNT)) bus1 ();

    assign bus0.start = start;     assign bus1.start = start;
    assign bus0.ref_in = ref_in;   assign bus1.ref_in = ref_in;
    assign bus0.in_valid = in_valid; assign bus1.in_valid = in_valid;
    assign bus0.in_data = in_data; assign bus1.in_data = in_data;
    assign bus0.out_ready = out_ready; assign bus1.out_ready = out_ready;

    nearest_value_finder #(.WIDTH(WIDTH), .COUNT(COUNT), .MODE(MODE_NEAREST))
        u_dut_near (.clk(clk), .rst(rst), .bus(bus0));
    nearest_value_finder #(.WIDTH(WIDTH), .COUNT(COUNT), .MODE(MODE_FARTHEST))
        u_dut_far  (.clk(clk), .rst(rst), .bus(bus1));

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: scan the list, keep the first candidate with the best distance.
    task automatic model(input int r, input int c[COUNT], input bit far,
                         output int w_data, output int w_idx, output int w_dist);
        int d;
        w_data = c[0]; w_idx = 0;
        w_dist = (r > c[0]) ? r - c[0] : c[0] - r;
        for (int i = 1; i < COUNT; i++) begin
            d = (r > c[i]) ? r - c[i] : c[i] - r;
            if ((!far && d < w_dist) || (far && d > w_dist)) begin
                w_data = c[i]; w_idx = i; w_dist = d;
            end
        end
    endtask

    task automatic chk_result(input string tag, input int r, input int c[COUNT]);
        int d0, i0, s0, d1, i1, s1;
        model(r, c, 1'b0, d0, i0, s0);
        model(r, c, 1'b1, d1, i1, s1);
        chk({tag, " near data"},  32'(bus0.out_data),  32'(d0));
        chk({tag, " near index"}, 32'(bus0.out_index), 32'(i0));
        chk({tag, " near dist"},  32'(bus0.out_dist),  32'(s0));
        chk({tag, " far data"},   32'(bus1.out_data),  32'(d1));
        chk({tag, " far index"},  32'(bus1.out_index), 32'(i1));
        chk({tag, " far dist"},   32'(bus1.out_dist),  32'(s1));
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, " in_ready"},  32'({bus1.in_ready, bus0.in_ready}), 32'd0);
        chk({tag, " out_valid"}, 32'({bus1.out_valid, bus0.out_valid}), 32'd0);
        chk({tag, " busy"},      32'({bus1.busy, bus0.busy}), 32'd0);
        chk({tag, " out_data"},  32'({bus1.out_data, bus0.out_data}), 32'd0);
        chk({tag, " out_index"}, 32'({bus1.out_index, bus0.out_index}), 32'd0);
        chk({tag, " out_dist"},  32'({bus1.out_dist, bus0.out_dist}), 32'd0);
    endtask

    // All driving and sampling happens on the falling edge.
    task automatic do_start(input int r);
        start  = 1'b1;
        ref_in = WIDTH'(r);
        @(negedge clk);
        start = 1'b0;
        chk("in_ready after start", 32'({bus1.in_ready, bus0.in_ready}), 32'h3);
        chk("busy after start",     32'({bus1.busy, bus0.busy}), 32'h3);
    endtask

    // gap_max: max random stall cycles before each beat (start pulses during stalls).
    task automatic feed(input int c[COUNT], input int nbeats, input int gap_max);
        int g;
        for (int i = 0; i < nbeats; i++) begin
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            for (int k = 0; k < g; k++) begin
                in_valid = 1'b0;
                in_data  = WIDTH'($urandom);
                start    = $urandom_range(1, 0) == 1;
                ref_in   = WIDTH'($urandom);
                @(negedge clk);
                start = 1'b0;
            end
            chk("in_ready in scan", 32'({bus1.in_ready, bus0.in_ready}), 32'h3);
            in_valid = 1'b1;
            in_data  = WIDTH'(c[i]);
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = WIDTH'($urandom);
        end
    endtask

    // hold: cycles with out_ready low; start_with_ack: assert start alongside out_ready.
    task automatic finish_search(input string tag, input int r, input int c[COUNT],
                                 input int hold, input bit start_with_ack);
        chk({tag, " out_valid after last beat"}, 32'({bus1.out_valid, bus0.out_valid}), 32'h3);
        chk({tag, " in_ready in done"}, 32'({bus1.in_ready, bus0.in_ready}), 32'h0);
        chk_result(tag, r, c);
        for (int k = 0; k < hold; k++) begin
            start    = (k == 1);
            in_valid = 1'b1;
            in_data  = WIDTH'($urandom);
            @(negedge clk);
            start    = 1'b0;
            in_valid = 1'b0;
            chk({tag, " out_valid held"}, 32'({bus1.out_valid, bus0.out_valid}), 32'h3);
            chk_result({tag, " held"}, r, c);
        end
        out_ready = 1'b1;
        start     = start_with_ack;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        chk({tag, " idle after ack"}, 32'({bus1.busy, bus0.busy, bus1.out_valid, bus0.out_valid}), 32'h0);
        chk_result({tag, " retained"}, r, c);
        @(negedge clk);
        chk({tag, " no start on ack"}, 32'({bus1.busy, bus0.busy}), 32'h0);
    endtask

    task automatic search(input string tag, input int r, input int c[COUNT],
                          input int gap_max, input int hold, input bit start_with_ack);
        do_start(r);
        feed(c, COUNT, gap_max);
        finish_search(tag, r, c, hold, start_with_ack);
    endtask

    int cands[COUNT];
    int rr;

    initial begin
        repeat (3) @(negedge clk);
        chk_idle_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_idle_zero("post reset idle");

        cands = '{90, 105, 130, 99};
        search("basic", 100, cands, 0, 0, 1'b0);
        chk("basic near data abs", 32'(bus0.out_data), 32'd99);
        chk("basic far data abs",  32'(bus1.out_data), 32'd130);

        cands = '{45, 55, 60, 40};
        search("tie", 50, cands, 0, 0, 1'b0);
        chk("tie near index abs", 32'(bus0.out_index), 32'd0);

        cands = '{255, 0, 128, 1};
        search("extreme", 0, cands, 0, 0, 1'b0);
        chk("extreme far dist abs", 32'(bus1.out_dist), 32'd255);

        cands = '{17, 200, 3, 90};
        search("handshake", 77, cands, 3, 5, 1'b1);

        // Abort after two beats.
        cands = '{1, 2, 3, 4};
        do_start(200);
        feed(cands, 2, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle_zero("abort");
        @(negedge clk);
        chk_idle_zero("abort settle");

        cands = '{20, 5, 12, 9};
        search("after abort", 10, cands, 0, 0, 1'b0);
        chk("after abort near data abs", 32'(bus0.out_data), 32'd9);

        for (int t = 0; t < 25; t++) begin
            rr = int'($urandom_range(255, 0));
            for (int i = 0; i < COUNT; i++) begin
                // Bias some candidates to repeat so ties are exercised.
                if (i > 0 && $urandom_range(3, 0) == 0) cands[i] = cands[$urandom_range(i - 1, 0)];
                else cands[i] = int'($urandom_range(255, 0));
            end
            search("random", rr, cands, int'($urandom_range(3, 0)),
                   int'($urandom_range(4, 0)), $urandom_range(1, 0) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
